// File: rtl/ped_crossing_scheduler.sv
// Pedestrian-crossing scheduler. Two debounced request lanes hold their arterial
// green for walk + clearance, and a round-robin arbiter shares one buzzer between them.

module ped_crossing_lane #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned WALK_CYC     = 250000000,
  parameter int unsigned CLEAR_CYC    = 150000000,
  parameter int unsigned BLINK_CYC    = 12500000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic ped,
  input  logic green,
  output logic walk_active,
  output logic ped_light,
  output logic hold_green,
  output logic pend
);
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_WALK, ST_CLEAR} state_e;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_MAX    = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] WALK_LAST  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYC - 1);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, green_q;
  logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic             ped_light_q, ped_light_d;
  logic             hold_q, hold_d;
  logic             pend_q, pend_d;
  logic             press, green_rise, green_fall;

  // The press fires on the cycle the count would reach DEBOUNCE_CYC; saturation
  // keeps a held button from producing a second press.
  assign press      = sync2_q && (deb_cnt_q == DEB_LAST);
  assign green_rise = green & ~green_q;
  assign green_fall = ~green & green_q;

  // NOTE: every always_comb target gets a default first so no path infers a latch.
  always_comb begin
    deb_cnt_d   = '0;
    state_d     = state_q;
    timer_d     = timer_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    if (sync2_q) deb_cnt_d = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + CNT_W'(1);

    unique case (state_q)
      ST_IDLE: if (press) state_d = ST_PEND;
      ST_PEND: if (green_rise) begin
        state_d = ST_WALK;
        timer_d = '0;
      end
      ST_WALK: begin
        if (green_fall) state_d = ST_IDLE;
        else if (timer_q == WALK_LAST) begin
          state_d     = ST_CLEAR;
          timer_d     = '0;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else timer_d = timer_q + CNT_W'(1);
      end
      ST_CLEAR: begin
        if (green_fall || timer_q == CLEAR_LAST) state_d = ST_IDLE;
        else begin
          timer_d = timer_q + CNT_W'(1);
          if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
          end else blink_cnt_d = blink_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ped_light_d = (state_q == ST_WALK) || (state_q == ST_CLEAR && blink_on_q);
    hold_d      = (state_q == ST_WALK) || (state_q == ST_CLEAR);
    pend_d      = (state_q == ST_PEND);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      green_q     <= 1'b0;
      deb_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b0;
      ped_light_q <= 1'b0;
      hold_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      sync1_q     <= ped;
      sync2_q     <= sync1_q;
      green_q     <= green;
      deb_cnt_q   <= deb_cnt_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      ped_light_q <= ped_light_d;
      hold_q      <= hold_d;
      pend_q      <= pend_d;
    end
  end

  assign walk_active = (state_q == ST_WALK);
  assign ped_light   = ped_light_q;
  assign hold_green  = hold_q;
  assign pend        = pend_q;
endmodule

module ped_crossing_scheduler #(
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter int unsigned WALK_CYC     = 250000000,
  parameter int unsigned CLEAR_CYC    = 150000000,
  parameter int unsigned BLINK_CYC    = 12500000,
  parameter int unsigned CHIRP_CYC    = 25000000,
  parameter int unsigned CNT_W        = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic ped1,
  input  logic ped3,
  input  logic green1,
  input  logic green3,
  output logic ped_light1,
  output logic ped_light3,
  output logic hold_green1,
  output logic hold_green3,
  output logic pend1,
  output logic pend3,
  output logic buzzer,
  output logic buzzer_sel
);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(CHIRP_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_HALF = CNT_W'(CHIRP_CYC / 2);

  logic [1:0]       active;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic             rr_q, rr_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             sel_q, sel_d;
  logic             buzzer_q, buzzer_d;
  logic             dec_vld, dec_id;

  ped_crossing_lane #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .WALK_CYC(WALK_CYC), .CLEAR_CYC(CLEAR_CYC),
    .BLINK_CYC(BLINK_CYC), .CNT_W(CNT_W)
  ) u_lane1 (
    .clk(clk), .reset(reset), .ped(ped1), .green(green1), .walk_active(active[0]),
    .ped_light(ped_light1), .hold_green(hold_green1), .pend(pend1)
  );

  ped_crossing_lane #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC), .WALK_CYC(WALK_CYC), .CLEAR_CYC(CLEAR_CYC),
    .BLINK_CYC(BLINK_CYC), .CNT_W(CNT_W)
  ) u_lane3 (
    .clk(clk), .reset(reset), .ped(ped3), .green(green3), .walk_active(active[1]),
    .ped_light(ped_light3), .hold_green(hold_green3), .pend(pend3)
  );

  // Grant is decided only at slot start; the selector then holds for the slot even
  // if the grantee stops walking, while the buzzer itself drops at once.
  always_comb begin
    slot_d    = (slot_q == SLOT_LAST) ? '0 : slot_q + CNT_W'(1);
    dec_vld   = 1'b0;
    dec_id    = rr_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    gnt_vld_d = gnt_vld_q & active[sel_q];

    if (active[rr_q]) begin
      dec_vld = 1'b1;
      dec_id  = rr_q;
    end else if (active[~rr_q]) begin
      dec_vld = 1'b1;
      dec_id  = ~rr_q;
    end

    if (slot_q == '0) begin
      gnt_vld_d = dec_vld;
      if (dec_vld) begin
        sel_d = dec_id;
        rr_d  = ~dec_id;
      end
    end

    buzzer_d = gnt_vld_d && (slot_q < SLOT_HALF);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q    <= '0;
      rr_q      <= 1'b0;
      gnt_vld_q <= 1'b0;
      sel_q     <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      rr_q      <= rr_d;
      gnt_vld_q <= gnt_vld_d;
      sel_q     <= sel_d;
      buzzer_q  <= buzzer_d;
    end
  end

  assign buzzer     = buzzer_q;
  assign buzzer_sel = sel_q;
endmodule

// File: tb/tb_ped_crossing_scheduler.sv
// Scoreboard bench: each stimulus step queues the outputs it should cause, tagged
// with the cycle they are due; the negedge sampler pops and compares them.

module tb_ped_crossing_scheduler;
  localparam int DEB = 4, WALK = 20, CLR = 12, BLINK = 3, CHIRP = 4;
  localparam int L1 = 0, L3 = 1, H1 = 2, H3 = 3, P1 = 4, P3 = 5, BZ = 6, SEL = 7;

  typedef struct {
    int    due;
    string tag;
    int    sig;
    logic  exp;
  } sb_item_t;

  logic clk = 1'b0, reset = 1'b0;
  logic ped1 = 1'b0, ped3 = 1'b0, green1 = 1'b0, green3 = 1'b0;
  logic ped_light1, ped_light3, hold_green1, hold_green3, pend1, pend3, buzzer, buzzer_sel;
  logic [7:0] outs;
  sb_item_t sb[$];
  int cyc = 0, rel_cyc = 0, n_tests = 0, n_fail = 0;
  int k, g;

  ped_crossing_scheduler #(
    .DEBOUNCE_CYC(DEB), .WALK_CYC(WALK), .CLEAR_CYC(CLR), .BLINK_CYC(BLINK), .CHIRP_CYC(CHIRP)
  ) dut (
    .clk(clk), .reset(reset), .ped1(ped1), .ped3(ped3), .green1(green1), .green3(green3),
    .ped_light1(ped_light1), .ped_light3(ped_light3), .hold_green1(hold_green1),
    .hold_green3(hold_green3), .pend1(pend1), .pend3(pend3), .buzzer(buzzer),
    .buzzer_sel(buzzer_sel)
  );

  assign outs = {buzzer_sel, buzzer, pend3, pend1, hold_green3, hold_green1, ped_light3, ped_light1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int due, input string tag, input int sig, input logic exp);
    sb_item_t it;
    it.due = due; it.tag = tag; it.sig = sig; it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic push_range(input int from, input int to, input string tag, input int sig,
                            input logic exp);
    for (int c = from; c <= to; c++) push(c, tag, sig, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int slot_of(input int x);
    return (x - rel_cyc) % CHIRP;
  endfunction

  // Buzzer seen at cycle c for a lone walker (or a shared slot) in WALK over [a,b].
  function automatic logic buz_exp(input int c, input int a, input int b);
    int x;
    x = c - 1;
    if (x < a || x > b) return 1'b0;
    return (slot_of(x) < CHIRP / 2) && ((x - slot_of(x)) >= a);
  endfunction

  function automatic int first_start(input int a);
    return a + ((CHIRP - slot_of(a)) % CHIRP);
  endfunction

  // Full walk from a green rise driven after edge g: 20 solid, 12 flashing, then idle.
  task automatic expect_walk(input int g0, input int l, input int h, input int p, input string nm);
    push(g0 + 1, {nm, "_pend_hi"}, p, 1'b1);
    push(g0 + 2, {nm, "_pend_lo"}, p, 1'b0);
    push(g0 + 1, {nm, "_lamp_pre"}, l, 1'b0);
    push_range(g0 + 2, g0 + 21, {nm, "_lamp_walk"}, l, 1'b1);
    for (int i = 0; i < CLR; i++) push(g0 + 22 + i, {nm, "_lamp_flash"}, l, ((i / BLINK) % 2) == 0);
    push(g0 + 34, {nm, "_lamp_end"}, l, 1'b0);
    push_range(g0 + 2, g0 + 33, {nm, "_hold"}, h, 1'b1);
    push(g0 + 34, {nm, "_hold_end"}, h, 1'b0);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].tag, {31'd0, outs[sb[i].sig]}, {31'd0, sb[i].exp});
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    // Reset state
    tick(1);
    check("reset_outs", {24'd0, outs}, 32'd0);
    tick(2);
    reset = 1'b1;
    rel_cyc = cyc;

    // Short bounces never qualify, then a held press latches once after 7 cycles
    tick(1); k = cyc;
    push_range(k + 1, k + 20, "glitch_pend1", P1, 1'b0);
    repeat (3) begin
      ped1 = 1'b1; tick(3);
      ped1 = 1'b0; tick(2);
    end
    tick(5);
    k = cyc;
    ped1 = 1'b1;
    push(k + 6, "press_lat_early", P1, 1'b0);
    push_range(k + 7, k + 15, "press_lat", P1, 1'b1);
    tick(10); ped1 = 1'b0;
    tick(5);

    // Crossing 1 walk, single owner on the buzzer, press during walk ignored
    g = cyc;
    green1 = 1'b1;
    expect_walk(g, L1, H1, P1, "walk1");
    push_range(g + 2, g + 50, "walk1_no_requeue", P1, 1'b0);
    for (int c = g + 1; c <= g + 26; c++) begin
      push(c, "walk1_buz", BZ, buz_exp(c, g + 1, g + 20));
      push(c, "walk1_sel", SEL, 1'b0);
    end
    tick(5); ped1 = 1'b1;
    tick(6); ped1 = 1'b0;
    tick(29); green1 = 1'b0;
    tick(2); green1 = 1'b1;
    push_range(g + 43, g + 48, "walk1_no_rewalk", L1, 1'b0);
    tick(8); green1 = 1'b0;
    tick(2);

    // Green 3 already high at press: pend holds until a fresh rise
    green3 = 1'b1;
    tick(3); k = cyc;
    ped3 = 1'b1;
    push(k + 6, "pend3_early", P3, 1'b0);
    push_range(k + 7, k + 14, "pend3_wait", P3, 1'b1);
    push_range(k + 1, k + 14, "lamp3_wait", L3, 1'b0);
    tick(8); ped3 = 1'b0;
    tick(6); green3 = 1'b0;
    tick(3); g = cyc;
    green3 = 1'b1;
    expect_walk(g, L3, H3, P3, "walk3");
    for (int c = g + 1; c <= g + 24; c++) begin
      push(c, "walk3_buz", BZ, buz_exp(c, g + 1, g + 20));
      push(c, "walk3_sel", SEL, (c - 1) >= first_start(g + 1));
    end
    tick(36);

    // Both crossings walking: selector alternates starting with crossing 1
    green3 = 1'b0;
    tick(2);
    ped1 = 1'b1; ped3 = 1'b1;
    tick(6); ped1 = 1'b0; ped3 = 1'b0;
    tick(4); g = cyc;
    green1 = 1'b1; green3 = 1'b1;
    push_range(g + 2, g + 21, "both_lamp1", L1, 1'b1);
    push_range(g + 2, g + 21, "both_lamp3", L3, 1'b1);
    for (int j = 0; first_start(g + 1) + 4 * j <= g + 20; j++) begin
      for (int c = first_start(g + 1) + 4 * j + 1; c <= first_start(g + 1) + 4 * j + 4; c++) begin
        push(c, "both_sel", SEL, (j % 2) == 1);
        push(c, "both_buz", BZ, buz_exp(c, g + 1, g + 20));
      end
    end
    tick(36);
    green1 = 1'b0; green3 = 1'b0;
    tick(2);

    // Green 1 drops in the 5th walk cycle: abort, request discarded
    ped1 = 1'b1;
    tick(6); ped1 = 1'b0;
    tick(4); g = cyc;
    green1 = 1'b1;
    push_range(g + 2, g + 6, "abort_lamp_on", L1, 1'b1);
    push_range(g + 2, g + 6, "abort_hold_on", H1, 1'b1);
    push_range(g + 7, g + 20, "abort_lamp_off", L1, 1'b0);
    push_range(g + 7, g + 12, "abort_hold_off", H1, 1'b0);
    push_range(g + 7, g + 12, "abort_pend", P1, 1'b0);
    tick(5); green1 = 1'b0;
    tick(4); green1 = 1'b1;
    tick(12); green1 = 1'b0;
    tick(2);

    // Press completing in the same cycle as a green rise only latches the request
    k = cyc;
    ped1 = 1'b1;
    tick(5); green1 = 1'b1;
    push_range(k + 7, k + 14, "same_cyc_pend", P1, 1'b1);
    push_range(k + 6, k + 14, "same_cyc_lamp", L1, 1'b0);
    tick(3); ped1 = 1'b0;
    tick(6); green1 = 1'b0;
    tick(2); g = cyc;
    green1 = 1'b1;
    push(g + 1, "same_cyc_walk_pre", L1, 1'b0);
    push(g + 2, "same_cyc_walk", L1, 1'b1);
    tick(36); green1 = 1'b0;
    tick(2);

    // Reset during clearance of both crossings
    ped1 = 1'b1; ped3 = 1'b1;
    tick(6); ped1 = 1'b0; ped3 = 1'b0;
    tick(4); g = cyc;
    green1 = 1'b1; green3 = 1'b1;
    push_range(g + 22, g + 24, "clr_lamp1", L1, 1'b1);
    push_range(g + 22, g + 24, "clr_lamp3", L3, 1'b1);
    push_range(g + 22, g + 24, "clr_hold1", H1, 1'b1);
    push_range(g + 22, g + 24, "clr_hold3", H3, 1'b1);
    tick(25);
    reset = 1'b0;
    #1 check("reset_async", {24'd0, outs}, 32'd0);
    tick(2);
    check("reset_held", {24'd0, outs}, 32'd0);
    reset = 1'b1;
    rel_cyc = cyc;
    green1 = 1'b0; green3 = 1'b0;
    tick(2); g = cyc;
    green1 = 1'b1; green3 = 1'b1;
    push_range(g + 1, g + 10, "post_rst_lamp1", L1, 1'b0);
    push_range(g + 1, g + 10, "post_rst_lamp3", L3, 1'b0);
    push_range(g + 1, g + 10, "post_rst_pend1", P1, 1'b0);
    push_range(g + 1, g + 10, "post_rst_pend3", P3, 1'b0);
    push_range(g + 1, g + 10, "post_rst_hold1", H1, 1'b0);
    tick(12);

    tick(2);
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ped_crossing_scheduler.md
Name: ped_crossing_scheduler

Overview:
- Pedestrian-crossing scheduler between the push buttons and the two intersection light controllers.
- Debounces ped1/ped3, latches each request, and grants a walk window only on the next rising edge of the matching arterial green (green1/green3).
- Holds that green for the full walk plus clearance, and time-shares the single buzzer between the two crossings.

Parameters:
DEBOUNCE_CYC, 500000, consecutive stable-high cycles for a valid press (10 ms @ 50 MHz)
WALK_CYC, 250000000, solid walk duration in cycles (5 s)
CLEAR_CYC, 150000000, flashing clearance duration in cycles (3 s)
BLINK_CYC, 12500000, half-period of clearance flash
CHIRP_CYC, 25000000, buzzer arbitration slot length; buzzer on for first CHIRP_CYC/2 of slot
CNT_W, 32, width of all timers

Ports:
clk  in  1  50 MHz system clock
reset  in  1  asynchronous, active-low reset
ped1  in  1  crossing-1 button, asynchronous, raw
ped3  in  1  crossing-3 button, asynchronous, raw
green1  in  1  green of signal 1, synchronous to clk
green3  in  1  green of signal 3, synchronous to clk
ped_light1  out  1  walk lamp, crossing 1
ped_light3  out  1  walk lamp, crossing 3
hold_green1  out  1  request to light controller to keep green1 asserted
hold_green3  out  1  request to light controller to keep green3 asserted
pend1  out  1  request latched, waiting for green1
pend3  out  1  request latched, waiting for green3
buzzer  out  1  shared audible-cue drive
buzzer_sel  out  1  buzzer owner: 0 = crossing 1, 1 = crossing 3

Behaviour:
- Reset (reset=0, async): all outputs 0; both FSMs IDLE; all timers 0; sync/debounce flops 0; RR pointer = crossing 1. Assertion mid-walk drops lamps, hold and buzzer immediately.
- Input conditioning: ped1/ped3 pass through 2-flop synchronisers.
- Debounce counter increments while the synced level is 1; it clears on any 0.
- press_n is a 1-cycle pulse when the counter reaches DEBOUNCE_CYC. The counter then saturates, so a held button yields exactly one press.
- Press latency: 2 sync cycles + DEBOUNCE_CYC.
- Green edge detection: green_rise_n = green_n & ~green_n_q; green_n_q is registered each cycle.
- Per-crossing FSM (n = 1, 3), states IDLE, PEND, WALK, CLEAR:
  - IDLE: on press_n -> PEND.
  - PEND: pend_n=1. On green_rise_n -> WALK, timer cleared. If green is already high when the press arrives, wait for the next rising edge. Additional presses are ignored.
  - WALK: ped_light_n=1, hold_green_n=1. After WALK_CYC cycles -> CLEAR, timer cleared.
  - CLEAR: hold_green_n=1. ped_light_n is 1 for the first BLINK_CYC cycles, then toggles every BLINK_CYC. After CLEAR_CYC cycles -> IDLE, ped_light_n=0.
  - Presses in WALK/CLEAR are ignored; they are not queued.
  - Abort: green_n falling while in WALK or CLEAR -> IDLE next cycle, lamp and hold cleared, request discarded.
- Outputs are registered; they change one clk after the FSM state changes.
- Buzzer arbiter:
  - Requester n is active while its FSM is in WALK.
  - Slot counter runs 0..CHIRP_CYC-1 continuously from reset.
  - At slot start (count 0), grant goes to the requester pointed to by RR if it is active, else to the other if that one is active, else none. The pointer then moves to the crossing not granted.
  - buzzer_sel = granted crossing, held for the whole slot.
  - buzzer = 1 when a grant exists and slot count < CHIRP_CYC/2.
  - A grantee leaving WALK mid-slot drops buzzer at once; buzzer_sel holds until the next slot.
  - With no grant: buzzer=0, buzzer_sel keeps its last value.
- Simultaneous events:
  - Both crossings are independent; both may be in WALK together.
  - Press and green_rise in the same cycle while IDLE: go to PEND only; WALK waits for the next rise.

Test Plan (DEBOUNCE_CYC=4, WALK_CYC=20, CLEAR_CYC=12, BLINK_CYC=3, CHIRP_CYC=4):
- ped1 high 3 cycles then low, repeated -> pend1 never asserts. ped1 held 10 cycles -> pend1 rises exactly once, 7 cycles after ped1 rise (2 sync + 4 debounce + 1 register).
- pend1=1, green1 rises -> next cycle ped_light1=1, hold_green1=1 for 20 cycles. Then ped_light1 pattern 1,1,1,0,0,0,1,1,1,0,0,0 over 12 cycles, then IDLE with hold_green1=0.
- green3 already high when press3 completes -> pend3 stays 1, ped_light3 stays 0. Green3 goes low then high -> WALK starts.
- Both crossings in WALK -> buzzer_sel alternates 0,1,0,1 every 4 cycles; buzzer=1 for the first 2 cycles of each slot. Only crossing 3 walking -> buzzer_sel=1 every slot.
- green1 falls at cycle 5 of WALK -> next cycle ped_light1=0, hold_green1=0, FSM IDLE; a new press is required for the next walk.
- reset driven low during CLEAR of both crossings -> all outputs 0 asynchronously. After release, no walk occurs until a fresh debounced press.
